// File: rtl/btn_conditioner.sv
// Multi-channel button front end: 2-FF sync, counter debounce, press/release pulses, stretched push, long-press/auto-repeat.
// Latency DEB_CYC+3 cycles from a BTN edge to PRESS/RELEASE; no backpressure, all outputs are free-running levels/pulses.
module btn_conditioner #(
   parameter int NCH        = 4,
   parameter int DEB_CYC    = 1_000_000,
   parameter int HOLD_CYC   = 10_000_000,
   parameter int LONG_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter bit REPEAT_EN  = 1'b1,
   parameter int CW         = 26
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic [NCH-1:0] btn_i,
   output logic [NCH-1:0] btn_lvl_o,
   output logic [NCH-1:0] press_o,
   output logic [NCH-1:0] release_o,
   output logic [NCH-1:0] push_o,
   output logic [NCH-1:0] long_p_o,
   output logic [NCH-1:0] repeat_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2} state_e;

   localparam logic [CW-1:0] DEB_T  = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] LONG_T = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYC - 1);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic          sync1_q, sync2_q;
      logic          lvl_q, lvl_d, lvl_dly_q;
      logic [CW-1:0] dcnt_q, dcnt_d;
      logic [CW-1:0] hcnt_q, hcnt_d;
      logic [CW-1:0] lcnt_q, lcnt_d;
      logic [CW-1:0] rcnt_q, rcnt_d;
      state_e        state_q, state_d;
      logic          press_q, release_q, push_q, long_q, long_d, rep_q, rep_d;
      logic          rise, fall;

      assign rise = lvl_q & ~lvl_dly_q;
      assign fall = ~lvl_q & lvl_dly_q;

      // A change is accepted only after DEB_CYC consecutive disagreeing samples.
      always_comb begin
         lvl_d  = lvl_q;
         dcnt_d = '0;
         if (sync2_q != lvl_q) begin
            if (dcnt_q == DEB_T) begin
               lvl_d  = sync2_q;
               dcnt_d = '0;
            end else begin
               dcnt_d = dcnt_q + CW'(1);
            end
         end
      end

      always_comb begin
         hcnt_d = hcnt_q;
         if (rise) begin
            hcnt_d = HOLD_T;
         end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - CW'(1);
         end
      end

      // A release always beats a terminal count landing in the same cycle.
      always_comb begin
         state_d = state_q;
         lcnt_d  = lcnt_q;
         rcnt_d  = rcnt_q;
         long_d  = 1'b0;
         rep_d   = 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = HELD;
                  lcnt_d  = '0;
               end
            end
            HELD: begin
               if (fall) begin
                  state_d = IDLE;
               end else if (lcnt_q == LONG_T) begin
                  state_d = LONG;
                  long_d  = 1'b1;
                  rcnt_d  = '0;
               end else begin
                  lcnt_d = lcnt_q + CW'(1);
               end
            end
            LONG: begin
               if (fall) begin
                  state_d = IDLE;
               end else if (rcnt_q == REP_T) begin
                  rep_d  = REPEAT_EN;
                  rcnt_d = '0;
               end else begin
                  rcnt_d = rcnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            lcnt_q    <= '0;
            rcnt_q    <= '0;
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            push_q    <= 1'b0;
            long_q    <= 1'b0;
            rep_q     <= 1'b0;
         end else begin
            sync1_q   <= btn_i[g];
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            lcnt_q    <= lcnt_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
            press_q   <= rise;
            release_q <= fall;
            // Using the live level lets PUSH rise together with PRESS.
            push_q    <= lvl_q | (hcnt_q != '0);
            long_q    <= long_d;
            rep_q     <= rep_d;
         end
      end

      assign btn_lvl_o[g] = lvl_q;
      assign press_o[g]   = press_q;
      assign release_o[g] = release_q;
      assign push_o[g]    = push_q;
      assign long_p_o[g]  = long_q;
      assign repeat_o[g]  = rep_q;
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenario table, hand-written corner sequences and random stimulus
// checked every cycle against a timestamp-based reference model.
module tb_btn_conditioner;
   localparam int NCH  = 2;
   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int LONG = 20;
   localparam int REP  = 5;
   localparam bit REP_EN = 1'b1;
   localparam int MASK = (1 << DEB) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [NCH-1:0] btn = '0;
   logic [NCH-1:0] lvl_o, press_o, rel_o, push_o, long_o, rep_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   btn_conditioner #(
      .NCH(NCH), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .LONG_CYC(LONG),
      .REPEAT_CYC(REP), .REPEAT_EN(REP_EN), .CW(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .btn_i(btn),
      .btn_lvl_o(lvl_o), .press_o(press_o), .release_o(rel_o),
      .push_o(push_o), .long_p_o(long_o), .repeat_o(rep_o)
   );

   // Reference model: debounced level from a window of synced samples, everything else from the age since PRESS.
   int m_b1[NCH], m_b2[NCH], m_hist[NCH], m_lc[NCH], m_lp[NCH], m_age[NCH];
   bit m_av[NCH], m_alive[NCH];
   logic [NCH-1:0] e_lvl = '0, e_press = '0, e_rel = '0, e_push = '0, e_long = '0, e_rep = '0;

   task automatic model_step();
      int s;
      int nl;
      for (int c = 0; c < NCH; c++) begin
         if (!rst_n) begin
            m_b1[c] = 0; m_b2[c] = 0; m_hist[c] = 0; m_lc[c] = 0; m_lp[c] = 0;
            m_age[c] = 0; m_av[c] = 1'b0; m_alive[c] = 1'b0;
            e_lvl[c] = 1'b0; e_press[c] = 1'b0; e_rel[c] = 1'b0;
            e_push[c] = 1'b0; e_long[c] = 1'b0; e_rep[c] = 1'b0;
         end else begin
            s = m_b2[c];
            m_b2[c] = m_b1[c];
            m_b1[c] = int'(btn[c]);
            e_press[c] = (m_lc[c] == 1 && m_lp[c] == 0);
            e_rel[c]   = (m_lc[c] == 0 && m_lp[c] == 1);
            if (e_press[c]) begin
               m_age[c] = 0; m_av[c] = 1'b1; m_alive[c] = 1'b1;
            end else if (m_av[c] && m_age[c] < 100000) begin
               m_age[c]++;
            end
            if (m_lc[c] == 0) m_alive[c] = 1'b0;
            e_push[c] = (m_lc[c] == 1) || (m_av[c] && m_age[c] < HOLD);
            e_long[c] = m_alive[c] && m_age[c] == LONG;
            e_rep[c]  = REP_EN && m_alive[c] && m_age[c] > LONG && ((m_age[c] - LONG) % REP) == 0;
            m_hist[c] = ((m_hist[c] << 1) | s) & MASK;
            nl = m_lc[c];
            if (m_lc[c] == 0 && m_hist[c] == MASK) nl = 1;
            else if (m_lc[c] == 1 && m_hist[c] == 0) nl = 0;
            m_lp[c] = m_lc[c];
            m_lc[c] = nl;
            e_lvl[c] = (nl == 1);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check($sformatf("cycle %0d outputs", cyc),
            32'({lvl_o, press_o, rel_o, push_o, long_o, rep_o}),
            32'({e_lvl, e_press, e_rel, e_push, e_long, e_rep}));
   endtask

   typedef struct {
      int ch; int width; int n_press; int lat; int push_w; int n_rel; int n_long; int n_rep;
   } vec_t;
   vec_t vecs[8];

   task automatic run_vec(input int idx);
      int pc, lat, pw, rc, lc, rpc, other, pp_bad;
      int ch;
      ch = vecs[idx].ch;
      pc = 0; lat = -1; pw = 0; rc = 0; lc = 0; rpc = 0; other = 0; pp_bad = 0;
      btn[ch] = 1'b1;
      for (int k = 1; k <= vecs[idx].width + 70; k++) begin
         tick();
         if (k == vecs[idx].width) btn[ch] = 1'b0;
         if (press_o[ch]) begin
            pc++;
            if (lat < 0) lat = k;
            if (!push_o[ch]) pp_bad++;
         end
         if (push_o[ch]) pw++;
         if (rel_o[ch]) rc++;
         if (long_o[ch]) lc++;
         if (rep_o[ch]) rpc++;
         if (press_o[1-ch] || push_o[1-ch] || long_o[1-ch] || lvl_o[1-ch]) other++;
      end
      check($sformatf("vec%0d press count", idx), pc, vecs[idx].n_press);
      check($sformatf("vec%0d press latency", idx), lat, vecs[idx].lat);
      check($sformatf("vec%0d push width", idx), pw, vecs[idx].push_w);
      check($sformatf("vec%0d release count", idx), rc, vecs[idx].n_rel);
      check($sformatf("vec%0d long count", idx), lc, vecs[idx].n_long);
      check($sformatf("vec%0d repeat count", idx), rpc, vecs[idx].n_rep);
      check($sformatf("vec%0d push with press", idx), pp_bad, 0);
      check($sformatf("vec%0d other channel quiet", idx), other, 0);
   endtask

   initial begin
      int first_press, first_long, first_rep;
      int rem[NCH];

      vecs[0] = '{0,  3, 0, -1,  0, 0, 0, 0};
      vecs[1] = '{0,  4, 1,  7, 10, 1, 0, 0};
      vecs[2] = '{0,  6, 1,  7, 10, 1, 0, 0};
      vecs[3] = '{1, 15, 1,  7, 15, 1, 0, 0};
      vecs[4] = '{1, 20, 1,  7, 20, 1, 0, 0};
      vecs[5] = '{1, 21, 1,  7, 21, 1, 1, 0};
      vecs[6] = '{0, 26, 1,  7, 26, 1, 1, 1};
      vecs[7] = '{1, 40, 1,  7, 40, 1, 1, 3};

      // Reset with both buttons held, then release reset.
      #2 rst_n = 1'b0;
      btn = 2'b11;
      repeat (4) tick();
      check("reset outputs", 32'({lvl_o, press_o, rel_o, push_o, long_o, rep_o}), 32'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) check("press before latency", 32'(press_o), 32'd0);
         if (k == 7) check("press after reset release", 32'(press_o), 32'b11);
      end
      btn = 2'b00;
      repeat (40) tick();

      for (int i = 0; i < 8; i++) run_vec(i);

      // ch0 PRESS lands in the same cycle as ch1 RELEASE.
      btn[1] = 1'b1;
      repeat (12) tick();
      btn = 2'b01;
      repeat (7) tick();
      check("concurrent press", 32'(press_o), 32'b01);
      check("concurrent release", 32'(rel_o), 32'b10);
      btn = 2'b00;
      repeat (40) tick();

      // Reset pulled while ch1 is in the long-press phase, button kept held.
      btn[1] = 1'b1;
      repeat (35) tick();
      check("long phase reached", 32'({lvl_o[1], push_o[1]}), 32'b11);
      rst_n = 1'b0;
      #1;
      check("async reset drop", 32'({lvl_o, press_o, rel_o, push_o, long_o, rep_o}), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      first_press = -1; first_long = -1; first_rep = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (press_o[1] && first_press < 0) first_press = k;
         if (long_o[1] && first_long < 0) first_long = k;
         if (rep_o[1] && first_rep < 0) first_rep = k;
      end
      check("fresh press after reset", first_press, 7);
      check("long after reset", first_long, 27);
      check("first repeat after reset", first_rep, 32);
      btn = 2'b00;
      repeat (40) tick();

      // Random glitches, short and long presses, occasional reset pulses.
      for (int c = 0; c < NCH; c++) rem[c] = $urandom_range(1, 8);
      for (int t = 0; t < 2500; t++) begin
         tick();
         for (int c = 0; c < NCH; c++) begin
            rem[c]--;
            if (rem[c] <= 0) begin
               btn[c] = ~btn[c];
               rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            end
         end
         rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      end
      rst_n = 1'b1;
      btn = 2'b00;
      repeat (80) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
